// File: rtl/uart_xfer_arbiter.sv
// uart_xfer_arbiter
//   Shares one UART host register-transaction engine between NREQ on-chip
//   requesters. Arbitration is round-robin at transaction granularity; the
//   owner's command, write beats and read beats are forwarded to the engine.
//   A watchdog aborts transactions that stall in the data or completion phase.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
//   high. A requester holds req_valid and its fields stable until req_ready.
//   m_rvalid has no back-pressure. req_done/req_err/cmd_abort are 1-cycle pulses.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/ready/write       per-requester command handshake and direction
//   req_addr/len/wdata          packed per-requester address, len-1, write beat
//   req_wvalid/wready           per-requester write-beat handshake
//   req_rdata, req_rvalid       read beat (data broadcast, valid to owner only)
//   req_done, req_err           completion / abort pulses to the owner
//   grant                       one-hot owner, 0 when idle
//   cmd_*                       command channel to the engine
//   m_wdata/wvalid/wready       write beats to the engine
//   m_rdata/rvalid, m_done      read beats and completion from the engine
//   cmd_abort                   tells the engine to drop the transaction
//   dbg_state                   FSM state (0 IDLE, 1 CMD, 2 DATA, 3 WAIT_DONE)
module uart_xfer_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 65535,
  parameter int CW          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*16-1:0]   req_addr,
  input  logic [NREQ*4-1:0]    req_len,
  input  logic [NREQ*16-1:0]   req_wdata,
  input  logic [NREQ-1:0]      req_wvalid,
  output logic [NREQ-1:0]      req_wready,
  output logic [15:0]          req_rdata,
  output logic [NREQ-1:0]      req_rvalid,
  output logic [NREQ-1:0]      req_done,
  output logic [NREQ-1:0]      req_err,
  output logic [NREQ-1:0]      grant,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic                 cmd_write,
  output logic [15:0]          cmd_addr,
  output logic [3:0]           cmd_len,
  output logic [15:0]          m_wdata,
  output logic                 m_wvalid,
  input  logic                 m_wready,
  input  logic [15:0]          m_rdata,
  input  logic                 m_rvalid,
  input  logic                 m_done,
  output logic                 cmd_abort,
  output logic [1:0]           dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2, WAIT_DONE = 2'd3} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   owner, owner_nx, rr_ptr, rr_ptr_nx;
  logic [NREQ-1:0] grant_nx;
  logic [3:0]      beat_cnt, beat_cnt_nx;
  logic [CW-1:0]   wd_cnt, wd_cnt_nx;
  logic            own_write, own_write_nx;

  // Unpack the per-requester buses so the owner can be selected by index.
  logic [15:0] addr_arr  [NREQ];
  logic [3:0]  len_arr   [NREQ];
  logic [15:0] wdata_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*16 +: 16];
    assign len_arr[g]   = req_len[g*4 +: 4];
    assign wdata_arr[g] = req_wdata[g*16 +: 16];
  end

  // Round-robin pick: first asserted request at or after rr_ptr, wrapping.
  logic          pick_found;
  logic [IW-1:0] pick_idx, cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IW'((int'(rr_ptr) + i) % NREQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  logic beat, last_beat, timeout, release_own;

  always_comb begin
    state_nx     = state;
    owner_nx     = owner;
    rr_ptr_nx    = rr_ptr;
    grant_nx     = grant;
    beat_cnt_nx  = beat_cnt;
    wd_cnt_nx    = wd_cnt;
    own_write_nx = own_write;
    req_ready    = '0;
    req_wready   = '0;
    req_rvalid   = '0;
    req_done     = '0;
    req_err      = '0;
    req_rdata    = '0;
    cmd_valid    = 1'b0;
    cmd_write    = 1'b0;
    cmd_addr     = '0;
    cmd_len      = '0;
    m_wdata      = '0;
    m_wvalid     = 1'b0;
    cmd_abort    = 1'b0;
    beat         = 1'b0;
    last_beat    = 1'b0;
    release_own  = 1'b0;
    timeout      = (wd_cnt == CW'(TIMEOUT_CYC));

    case (state)
      IDLE: begin
        if (pick_found) begin
          owner_nx = pick_idx;
          grant_nx = NREQ'(1) << pick_idx;
          state_nx = CMD;
        end
      end

      CMD: begin
        // Fields are taken live from the owner; m_done here is ignored and
        // the watchdog is held because the engine may legitimately be busy.
        cmd_valid = 1'b1;
        cmd_write = req_write[owner];
        cmd_addr  = addr_arr[owner];
        cmd_len   = len_arr[owner];
        if (cmd_ready) begin
          req_ready[owner] = 1'b1;
          beat_cnt_nx      = len_arr[owner];
          own_write_nx     = req_write[owner];
          wd_cnt_nx        = '0;
          state_nx         = DATA;
        end
      end

      DATA: begin
        if (own_write) begin
          m_wdata           = wdata_arr[owner];
          m_wvalid          = req_wvalid[owner];
          req_wready[owner] = m_wready;
          beat              = req_wvalid[owner] & m_wready;
        end else begin
          req_rdata         = m_rdata;
          req_rvalid[owner] = m_rvalid;
          beat              = m_rvalid;
        end
        last_beat = beat && (beat_cnt == 4'd0);
        wd_cnt_nx = (beat || m_done) ? '0 : wd_cnt + 1'b1;
        if (beat && !last_beat) beat_cnt_nx = beat_cnt - 4'd1;

        if (m_done) begin
          // Completion before the last beat is an engine-side error.
          req_done[owner] = 1'b1;
          req_err[owner]  = !last_beat;
          release_own     = 1'b1;
        end else if (last_beat) begin
          wd_cnt_nx = '0;
          state_nx  = WAIT_DONE;
        end else if (!beat && timeout) begin
          cmd_abort       = 1'b1;
          req_done[owner] = 1'b1;
          req_err[owner]  = 1'b1;
          release_own     = 1'b1;
        end
      end

      WAIT_DONE: begin
        wd_cnt_nx = wd_cnt + 1'b1;
        if (m_done) begin
          req_done[owner] = 1'b1;
          release_own     = 1'b1;
        end else if (timeout) begin
          cmd_abort       = 1'b1;
          req_done[owner] = 1'b1;
          req_err[owner]  = 1'b1;
          release_own     = 1'b1;
        end
      end

      default: state_nx = IDLE;
    endcase

    // Release: the pointer moves past the owner, so a re-request from the
    // same requester ranks behind every other pending one.
    if (release_own) begin
      state_nx  = IDLE;
      grant_nx  = '0;
      wd_cnt_nx = '0;
      rr_ptr_nx = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      grant     <= '0;
      beat_cnt  <= '0;
      wd_cnt    <= '0;
      own_write <= 1'b0;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      rr_ptr    <= rr_ptr_nx;
      grant     <= grant_nx;
      beat_cnt  <= beat_cnt_nx;
      wd_cnt    <= wd_cnt_nx;
      own_write <= own_write_nx;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_uart_xfer_arbiter.sv
// Directed bench for uart_xfer_arbiter: drives requesters and models the
// engine, with a scoreboard queue of expected write/read beats.
module tb_uart_xfer_arbiter;

  localparam int N  = 4;
  localparam int TO = 100;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_write, req_wvalid, req_wready;
  logic [N*16-1:0] req_addr, req_wdata;
  logic [N*4-1:0]  req_len;
  logic [15:0]     req_rdata;
  logic [N-1:0]    req_rvalid, req_done, req_err, grant;
  logic            cmd_valid, cmd_ready, cmd_write, m_wvalid, m_wready;
  logic            m_rvalid, m_done, cmd_abort;
  logic [15:0]     cmd_addr, m_wdata, m_rdata;
  logic [3:0]      cmd_len;
  logic [1:0]      dbg_state;

  always #5 clk = ~clk;

  uart_xfer_arbiter #(.NREQ(N), .TIMEOUT_CYC(TO), .CW(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .req_wvalid(req_wvalid), .req_wready(req_wready),
    .req_rdata(req_rdata), .req_rvalid(req_rvalid),
    .req_done(req_done), .req_err(req_err), .grant(grant),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_done(m_done),
    .cmd_abort(cmd_abort), .dbg_state(dbg_state)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] exp_q [$];
  logic [15:0] gold [logic [15:0]];
  logic [15:0] mem  [logic [15:0]];
  logic [15:0] wbuf [16];
  logic        proto_viol = 1'b0;

  // Requester must hold req_valid while its command is outstanding.
  always @(negedge clk)
    if (!rst && dbg_state == 2'd1 && (req_valid & grant) == '0) proto_viol <= 1'b1;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_write = '0; req_addr = '0; req_len = '0;
    req_wdata = '0; req_wvalid = '0; cmd_ready = 1'b0; m_wready = 1'b0;
    m_rdata = '0; m_rvalid = 1'b0; m_done = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_state"}, dbg_state, 0);
    chk({tag, "_cmd_valid"}, cmd_valid, 0);
    chk({tag, "_pulses"}, {req_ready, req_done, req_err, req_wready, req_rvalid}, 0);
    chk({tag, "_eng"}, {cmd_abort, m_wvalid, m_wdata, req_rdata, cmd_addr}, 0);
  endtask

  task automatic post(input int r, input logic wr, input logic [15:0] a, input logic [3:0] l);
    req_valid[r]       = 1'b1;
    req_write[r]       = wr;
    req_addr[r*16 +: 16] = a;
    req_len[r*4 +: 4]  = l;
  endtask

  task automatic serve_cmd(input int r, input logic wr, input logic [15:0] a, input logic [3:0] l);
    int guard = 0;
    settle();
    while (grant == '0 && guard < 20) begin
      nxt(); settle(); guard++;
    end
    chk("grant_owner", grant, 32'(1) << r);
    chk("cmd_addr", cmd_addr, a);
    chk("cmd_len", cmd_len, l);
    chk("cmd_write", cmd_write, wr);
    chk("ready_before_accept", req_ready, 0);
    repeat ($urandom_range(0, 2)) nxt();
    settle();
    chk("cmd_valid_held", cmd_valid, 1);
    cmd_ready = 1'b1;
    settle();
    chk("req_ready_pulse", req_ready, 32'(1) << r);
    nxt();
    cmd_ready    = 1'b0;
    req_valid[r] = 1'b0;
    settle();
    chk("state_data", dbg_state, 2);
  endtask

  task automatic write_beats(input int r, input int n, input logic [15:0] a, input logic [1:0] end_state);
    int i = 0;
    int guard = 0;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(wbuf[k]);
      gold[a + 16'(k)] = wbuf[k];
    end
    while (i < n && guard < 200) begin
      req_wvalid[r]          = 1'b1;
      req_wdata[r*16 +: 16]  = wbuf[i];
      m_wready               = ($urandom_range(0, 3) != 0);
      settle();
      chk("wready_route", req_wready, m_wready ? (32'(1) << r) : 0);
      chk("no_early_done", req_done, 0);
      if (m_wvalid && m_wready) begin
        chk("wdata", m_wdata, exp_q.pop_front());
        mem[a + 16'(i)] = m_wdata;
        i++;
      end
      nxt();
      guard++;
    end
    req_wvalid[r] = 1'b0;
    m_wready      = 1'b0;
    settle();
    chk("write_beat_count", i, n);
    chk("state_after_write", dbg_state, end_state);
  endtask

  task automatic read_beats(input int r, input int n, input logic [15:0] a, input logic [1:0] end_state);
    int i = 0;
    int guard = 0;
    for (int k = 0; k < n; k++) exp_q.push_back(gold[a + 16'(k)]);
    while (i < n && guard < 200) begin
      m_rvalid = ($urandom_range(0, 3) != 0);
      m_rdata  = mem.exists(a + 16'(i)) ? mem[a + 16'(i)] : 16'hdead;
      settle();
      chk("rvalid_route", req_rvalid, m_rvalid ? (32'(1) << r) : 0);
      if (m_rvalid) begin
        chk("rdata", req_rdata, exp_q.pop_front());
        i++;
      end
      nxt();
      guard++;
    end
    m_rvalid = 1'b0;
    settle();
    chk("read_beat_count", i, n);
    chk("state_after_read", dbg_state, end_state);
  endtask

  task automatic finish_xfer(input int r, input logic err, input int dly);
    repeat (dly) nxt();
    m_done = 1'b1;
    settle();
    chk("req_done", req_done, 32'(1) << r);
    chk("req_err", req_err, err ? (32'(1) << r) : 0);
    chk("no_abort", cmd_abort, 0);
    nxt();
    m_done = 1'b0;
    settle();
    chk("grant_released", grant, 0);
    chk("state_idle", dbg_state, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (3) nxt();
    settle();
    chk_quiet("reset");
    rst = 1'b0;
    nxt();
  endtask

  initial begin
    logic [15:0] v4 [4];
    int early;
    v4[0] = 16'h2345; v4[1] = 16'h9aef; v4[2] = 16'h7634; v4[3] = 16'h5555;
    rst = 1'b1;
    clear_inputs();
    repeat (3) nxt();
    settle();
    chk_quiet("por");
    m_rvalid = 1'b1; m_rdata = 16'hffff; m_done = 1'b1;
    settle();
    chk("rvalid_ignored_reset", {req_rvalid, req_rdata, req_done}, 0);
    m_rvalid = 1'b0; m_done = 1'b0;
    rst = 1'b0;
    nxt();
    m_rvalid = 1'b1; m_rdata = 16'h1234;
    settle();
    chk("rvalid_ignored_idle", {req_rvalid, req_rdata}, 0);
    m_rvalid = 1'b0;
    nxt();

    // Single write then read from requester 0.
    post(0, 1'b1, 16'h2008, 4'd0);
    settle();
    chk("arb_cycle_no_grant", grant, 0);
    chk("arb_cycle_no_cmd", cmd_valid, 0);
    serve_cmd(0, 1'b1, 16'h2008, 4'd0);
    wbuf[0] = 16'h8888;
    write_beats(0, 1, 16'h2008, 2'd3);
    finish_xfer(0, 1'b0, 2);
    post(0, 1'b0, 16'h2008, 4'd0);
    serve_cmd(0, 1'b0, 16'h2008, 4'd0);
    read_beats(0, 1, 16'h2008, 2'd3);
    finish_xfer(0, 1'b0, 1);

    // 16-beat burst from requester 1, then read back.
    for (int k = 0; k < 15; k++) wbuf[k] = 16'h1111 * 16'(k + 1);
    wbuf[15] = 16'habcd;
    post(1, 1'b1, 16'h2001, 4'd15);
    serve_cmd(1, 1'b1, 16'h2001, 4'd15);
    write_beats(1, 16, 16'h2001, 2'd3);
    finish_xfer(1, 1'b0, 0);
    post(1, 1'b0, 16'h2001, 4'd15);
    serve_cmd(1, 1'b0, 16'h2001, 4'd15);
    read_beats(1, 16, 16'h2001, 2'd3);
    finish_xfer(1, 1'b0, 3);

    // All four at once from rr_ptr=0, then re-requests.
    do_reset();
    for (int r = 0; r < N; r++) post(r, 1'b1, 16'h2000 + 16'(r), 4'd0);
    for (int r = 0; r < N; r++) begin
      serve_cmd(r, 1'b1, 16'h2000 + 16'(r), 4'd0);
      if (r == 3) begin
        post(0, 1'b1, 16'h2010, 4'd0);
        post(2, 1'b1, 16'h2012, 4'd0);
      end
      wbuf[0] = v4[r];
      write_beats(r, 1, 16'h2000 + 16'(r), 2'd3);
      finish_xfer(r, 1'b0, 1);
    end
    serve_cmd(0, 1'b1, 16'h2010, 4'd0);
    wbuf[0] = 16'h0a0a;
    write_beats(0, 1, 16'h2010, 2'd3);
    finish_xfer(0, 1'b0, 0);
    serve_cmd(2, 1'b1, 16'h2012, 4'd0);
    wbuf[0] = 16'h0c0c;
    write_beats(2, 1, 16'h2012, 2'd3);
    finish_xfer(2, 1'b0, 0);
    post(1, 1'b1, 16'h2011, 4'd0);
    serve_cmd(1, 1'b1, 16'h2011, 4'd0);
    post(0, 1'b1, 16'h2020, 4'd0);
    post(2, 1'b1, 16'h2022, 4'd0);
    wbuf[0] = 16'h0b0b;
    write_beats(1, 1, 16'h2011, 2'd3);
    finish_xfer(1, 1'b0, 0);
    serve_cmd(2, 1'b1, 16'h2022, 4'd0);
    wbuf[0] = 16'h2222;
    write_beats(2, 1, 16'h2022, 2'd3);
    finish_xfer(2, 1'b0, 0);
    serve_cmd(0, 1'b1, 16'h2020, 4'd0);
    wbuf[0] = 16'h2020;
    write_beats(0, 1, 16'h2020, 2'd3);
    finish_xfer(0, 1'b0, 0);

    // Watchdog: engine stops accepting write beats mid-burst.
    post(2, 1'b1, 16'h2100, 4'd7);
    serve_cmd(2, 1'b1, 16'h2100, 4'd7);
    wbuf[0] = 16'h5a5a; wbuf[1] = 16'ha5a5;
    write_beats(2, 2, 16'h2100, 2'd2);
    post(3, 1'b1, 16'h2200, 4'd0);
    req_wvalid[2] = 1'b1;
    early = 0;
    for (int k = 0; k < TO; k++) begin
      settle();
      if (cmd_abort || req_done != '0) early++;
      nxt();
    end
    settle();
    chk("wd_no_early_abort", early, 0);
    chk("wd_abort", cmd_abort, 1);
    chk("wd_done", req_done, 32'(1) << 2);
    chk("wd_err", req_err, 32'(1) << 2);
    nxt();
    req_wvalid[2] = 1'b0;
    settle();
    chk("wd_grant_clear", grant, 0);
    chk("wd_abort_one_cycle", cmd_abort, 0);
    serve_cmd(3, 1'b1, 16'h2200, 4'd0);
    wbuf[0] = 16'h3333;
    write_beats(3, 1, 16'h2200, 2'd3);
    finish_xfer(3, 1'b0, 0);

    // Early m_done during an 8-beat read after 3 beats.
    post(1, 1'b0, 16'h2001, 4'd7);
    serve_cmd(1, 1'b0, 16'h2001, 4'd7);
    read_beats(1, 3, 16'h2001, 2'd2);
    finish_xfer(1, 1'b1, 0);
    for (int k = 0; k < 3; k++) begin
      m_rvalid = 1'b1; m_rdata = 16'h4444;
      settle();
      chk("no_rvalid_after_done", req_rvalid, 0);
      nxt();
    end
    m_rvalid = 1'b0;

    // Asynchronous reset in the middle of a burst.
    for (int k = 0; k < 16; k++) wbuf[k] = 16'h7000 + 16'(k);
    post(0, 1'b1, 16'h2300, 4'd15);
    serve_cmd(0, 1'b1, 16'h2300, 4'd7 + 4'd8);
    write_beats(0, 4, 16'h2300, 2'd2);
    req_wvalid[0] = 1'b1; m_wready = 1'b1;
    settle();
    rst = 1'b1;
    settle();
    chk_quiet("mid_reset");
    clear_inputs();
    nxt();
    rst = 1'b0;
    nxt();
    post(3, 1'b1, 16'h2400, 4'd0);
    serve_cmd(3, 1'b1, 16'h2400, 4'd0);
    wbuf[0] = 16'h4321;
    write_beats(3, 1, 16'h2400, 2'd3);
    finish_xfer(3, 1'b0, 0);

    chk("protocol_hold", proto_viol, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_xfer_arbiter.md
Name: uart_xfer_arbiter

Overview:
- Shares the single UART host register-transaction engine between NREQ on-chip requesters.
- Each transaction is a single or burst write/read: 16-bit address, 4-bit burst length (beats = len+1, 1..16), 16-bit data beats.
- The block arbitrates round-robin at transaction granularity and forwards command, write-data and read-data handshakes to the engine.
- A watchdog aborts transactions that stall.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 65535, idle cycles allowed in DATA/WAIT_DONE before abort.
- CW, 16, watchdog counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NREQ  transaction request; held with its fields stable until req_ready.
- req_ready  out  NREQ  one-cycle pulse: command accepted by the engine.
- req_write  in  NREQ  1=write, 0=read.
- req_addr  in  NREQ*16  packed addresses; [15:12] selects the device block, [11:0] the offset.
- req_len  in  NREQ*4  packed burst length minus one.
- req_wdata  in  NREQ*16  packed write beats.
- req_wvalid  in  NREQ  write beat valid.
- req_wready  out  NREQ  write beat accepted.
- req_rdata  out  16  read beat, broadcast to all requesters.
- req_rvalid  out  NREQ  read beat valid for the owner only.
- req_done  out  NREQ  one-cycle completion pulse.
- req_err  out  NREQ  one-cycle pulse with req_done on abort or protocol error.
- grant  out  NREQ  one-hot current owner; 0 when idle.
- cmd_valid  out  1  command to the engine.
- cmd_ready  in  1  engine accepts the command.
- cmd_write  out  1  owner's req_write.
- cmd_addr  out  16  owner's address.
- cmd_len  out  4  owner's length.
- m_wdata  out  16  write beat to the engine.
- m_wvalid  out  1
- m_wready  in  1
- m_rdata  in  16  read beat from the engine.
- m_rvalid  in  1  read beat; no back-pressure.
- m_done  in  1  engine transaction-complete pulse.
- cmd_abort  out  1  one-cycle pulse telling the engine to drop the transaction.

Behaviour:
- Reset: all outputs 0; grant=0; rr_ptr=0; beat counter=0; watchdog=0; state IDLE. Reset asserted mid-transaction abandons it with no done/err pulse.
- States: IDLE, CMD, DATA, WAIT_DONE.
- IDLE:
  - If any req_valid is high, the owner is the first asserted index at or after rr_ptr (wrapping modulo NREQ).
  - grant is registered and state goes to CMD on the next cycle. No command is issued in the arbitration cycle (latency 1).
- CMD:
  - cmd_valid=1; cmd_write/addr/len are muxed combinationally from the owner.
  - On cmd_valid&cmd_ready: req_ready[owner] pulses that cycle; beat counter loads req_len; state goes to DATA.
  - If req_valid[owner] drops before acceptance, that is a requester protocol violation. The block still completes the command with the fields held, and the bench flags it.
- DATA, write:
  - m_wdata=owner's req_wdata; m_wvalid=req_wvalid[owner]; req_wready[owner]=m_wready. All other req_wready are 0.
  - A beat transfers when m_wvalid&m_wready.
- DATA, read:
  - req_rdata=m_rdata; req_rvalid[owner]=m_rvalid. All other req_rvalid are 0.
  - m_rvalid outside DATA, or on a write transaction, is ignored.
- Beat counting:
  - Each beat decrements the counter.
  - A beat with counter==0 is the last: state goes to WAIT_DONE, or straight to IDLE if m_done arrives in the same cycle.
- m_done handling:
  - In WAIT_DONE: req_done[owner] pulses; rr_ptr=(owner+1) mod NREQ; grant clears; state goes to IDLE.
  - In DATA before the last beat: req_done and req_err pulse together, then the same release sequence.
  - In CMD: ignored.
- Watchdog:
  - Clears on state entry and on every beat or m_done.
  - Increments each cycle in DATA/WAIT_DONE.
  - At TIMEOUT_CYC: cmd_abort, req_done[owner] and req_err[owner] pulse together; release as above.
  - It does not run in CMD, where the engine may be legitimately busy.
- Fairness: a requester holding req_valid continuously gets at most one transaction before every other pending requester is served once.
- A new request from the just-released owner in the release cycle is considered only in the next IDLE evaluation.

Test Plan:
- Single write then read from requester 0: write addr 16'h2008, len 0, data 16'h8888, then read the same address. Expect cmd_addr=16'h2008, one write beat, req_done[0], then req_rvalid[0] with 16'h8888.
- Burst from requester 1: write addr 16'h2001, len 15, data 16'h1111..16'hffff, then 16'habcd. Expect exactly 16 write beats; read back 16 beats matching in order; req_done pulses once per transaction.
- All four requesters assert at once with single writes to offsets 0..3 (16'h2345, 16'h9aef, 16'h7634, 16'h5555). Expect grant order 0,1,2,3. Then requester 0 re-requests while requester 2 is pending: after 3 completes the order is 0,2 (from rr_ptr=0); after 1 completes it is 2,0.
- Engine stalls (m_wready=0) for TIMEOUT_CYC=100 during a burst. Expect cmd_abort, req_done and req_err for the owner at cycle 100; grant=0 the next cycle; the next requester is served normally.
- m_done during a read burst after 3 of 8 beats -> req_done and req_err together; no further req_rvalid.
- Reset asserted mid-burst -> all outputs 0 immediately; after release, a fresh request from requester 3 is granted.
